// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - requester/master handshake bundle for the I2C transaction arbiter
interface i2c_txn_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  s_valid;
    logic [15:0] s_data;
    logic [1:0]  s_last;
    logic [1:0]  s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_first;
    logic        m_last;
    logic        m_ready;
    logic        m_done;
    logic        m_abort;
    logic [1:0]  err;

    modport master (
        input  req, s_valid, s_data, s_last, m_ready, m_done,
        output gnt, s_ready, m_valid, m_data, m_first, m_last, m_abort, err
    );

    modport slave (
        output req, s_valid, s_data, s_last, m_ready, m_done,
        input  gnt, s_ready, m_valid, m_data, m_first, m_last, m_abort, err
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - two-requester round-robin arbiter with stall watchdog for one I2C byte master
module i2c_txn_arbiter #(
    parameter int TIMEOUT_CYCLES = 27000
) (
    input  logic               clk,
    input  logic               rst,
    i2c_txn_arbiter_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN, ABORT} state_t;

    state_t        state, state_nx;
    logic [1:0]    gnt, gnt_nx;
    logic          last_srv, last_srv_nx;
    logic          first_pending, first_nx;
    logic [TW-1:0] timer, timer_nx, timer_inc;
    logic          abort_pulse, abort_nx;
    logic          g;
    logic          win;
    logic          accept;

    logic [1:0]    s_ready;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_first;
    logic          m_last;

    assign g         = gnt[1];
    assign timer_inc = timer + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            gnt           <= 2'b00;
            last_srv      <= 1'b1;
            first_pending <= 1'b0;
            timer         <= '0;
            abort_pulse   <= 1'b0;
        end else begin
            state         <= state_nx;
            gnt           <= gnt_nx;
            last_srv      <= last_srv_nx;
            first_pending <= first_nx;
            timer         <= timer_nx;
            abort_pulse   <= abort_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        gnt_nx      = gnt;
        last_srv_nx = last_srv;
        first_nx    = first_pending;
        timer_nx    = timer;
        abort_nx    = 1'b0;
        win         = 1'b0;
        accept      = 1'b0;
        s_ready     = 2'b00;
        m_valid     = 1'b0;
        m_data      = 8'h00;
        m_first     = 1'b0;
        m_last      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    // On a tie the requester that was not served last wins.
                    win      = (bus.req == 2'b11) ? ~last_srv : bus.req[1];
                    gnt_nx   = win ? 2'b10 : 2'b01;
                    first_nx = 1'b1;
                    timer_nx = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                m_valid    = bus.s_valid[g];
                m_data     = g ? bus.s_data[15:8] : bus.s_data[7:0];
                m_last     = bus.s_last[g];
                s_ready    = g ? {bus.m_ready, 1'b0} : {1'b0, bus.m_ready};
                m_first    = first_pending & m_valid;
                accept     = bus.s_valid[g] & bus.m_ready;
                if (accept) begin
                    first_nx = 1'b0;
                    timer_nx = '0;
                    if (bus.s_last[g]) begin
                        state_nx = DRAIN;
                    end
                end else if (timer_inc == TLIM) begin
                    state_nx = ABORT;
                    abort_nx = 1'b1;
                end else begin
                    timer_nx = timer_inc;
                end
            end
            DRAIN, ABORT: begin
                if (bus.m_done) begin
                    gnt_nx      = 2'b00;
                    last_srv_nx = g;
                    state_nx    = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 2'b00;
            end
        endcase
    end

    assign bus.gnt     = gnt;
    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_data  = m_data;
    assign bus.m_first = m_first;
    assign bus.m_last  = m_last;
    assign bus.m_abort = abort_pulse;
    assign bus.err     = abort_pulse ? gnt : 2'b00;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - directed and randomized self-checking bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    i2c_txn_arbiter_if bus();
    i2c_txn_arbiter #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, whether it is still sending, and how long it has stalled.
    int owner = -1;
    bit sending = 0;
    bit first = 0;
    int idle_run = 0;
    bit abort_now = 0;
    int last_srv = 1;
    bit rand_phase = 0;
    int exp_seq[2];
    int e_gnt, e_ready, e_valid, e_first, e_last, e_data;
    bit nxt_abort;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_s_ready", bus.s_ready, 0);
            chk("rst_m_valid", bus.m_valid, 0);
            chk("rst_m_abort", bus.m_abort, 0);
            chk("rst_err", bus.err, 0);
            owner = -1; sending = 0; first = 0; idle_run = 0; abort_now = 0; last_srv = 1;
        end else begin
            e_gnt = (owner < 0) ? 0 : (1 << owner);
            e_valid = 0; e_ready = 0; e_first = 0; e_last = 0; e_data = 0;
            if (owner >= 0 && sending) begin
                e_valid = bus.s_valid[owner];
                e_data  = bus.s_data[8*owner +: 8];
                e_last  = bus.s_last[owner];
                e_ready = bus.m_ready ? (1 << owner) : 0;
                e_first = first & e_valid;
            end
            chk("gnt", bus.gnt, e_gnt);
            chk("s_ready", bus.s_ready, e_ready);
            chk("m_valid", bus.m_valid, e_valid);
            chk("m_first", bus.m_first, e_first);
            chk("m_abort", bus.m_abort, abort_now);
            chk("err", bus.err, abort_now ? e_gnt : 0);
            if (e_valid != 0) begin
                chk("m_data", bus.m_data, e_data);
                chk("m_last", bus.m_last, e_last);
            end
            nxt_abort = 0;
            if (owner < 0) begin
                if (bus.req != 2'b00) begin
                    owner = (bus.req == 2'b11) ? 1 - last_srv : (bus.req[1] ? 1 : 0);
                    sending = 1; first = 1; idle_run = 0;
                end
            end else if (sending) begin
                if (bus.s_valid[owner] && bus.m_ready) begin
                    if (rand_phase) begin
                        chk("byte_order", bus.m_data, exp_seq[owner] & 255);
                        exp_seq[owner]++;
                    end
                    first = 0; idle_run = 0;
                    if (bus.s_last[owner]) sending = 0;
                end else begin
                    idle_run++;
                    if (idle_run == T) begin sending = 0; nxt_abort = 1; end
                end
            end else if (bus.m_done) begin
                last_srv = owner;
                owner = -1;
            end
            abort_now = nxt_abort;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input int i, input int n, input logic [7:0] base, input logic [3:0] pat, input string tag);
        int k = 0;
        int w = 0;
        bit got = 0;
        bit acc;
        bus.req[i] = 1'b1; bus.s_valid[i] = 1'b1; bus.s_data[8*i +: 8] = base;
        bus.s_last[i] = (n == 1); bus.m_ready = pat[0];
        while (k < n && w < 40) begin
            #3;
            if (bus.gnt != 2'b00 && !got) begin got = 1; chk({tag, "_grant"}, bus.gnt, 1 << i); end
            if (bus.gnt[i]) chk({tag, "_other_ready"}, bus.s_ready[1-i], 0);
            acc = bus.s_valid[i] & bus.s_ready[i];
            if (acc) begin
                chk({tag, "_byte"}, bus.m_data, (base + k) & 255);
                chk({tag, "_first"}, bus.m_first, (k == 0));
                k++;
            end
            chk({tag, "_no_abort"}, bus.m_abort, 0);
            tick(); w++;
            bus.m_ready = pat[w % 4];
            if (acc) begin
                if (k == n) begin
                    bus.s_valid[i] = 1'b0; bus.s_last[i] = 1'b0; bus.req[i] = 1'b0;
                end else begin
                    bus.s_data[8*i +: 8] = 8'(base + k); bus.s_last[i] = (k == n - 1);
                end
            end
        end
        chk({tag, "_completed"}, k, n);
        bus.m_ready = 1'b1; bus.m_done = 1'b1;
        #3 chk({tag, "_drain_gnt"}, bus.gnt, 1 << i);
        tick(); bus.m_done = 1'b0;
        #3 chk({tag, "_release"}, bus.gnt, 0);
        tick();
    endtask

    task automatic wait_acc(input int i, input string tag);
        int w = 0;
        #3;
        while (!(bus.s_valid[i] & bus.s_ready[i]) && w < 10) begin tick(); w++; #3; end
        chk({tag, "_accept"}, bus.s_valid[i] & bus.s_ready[i], 1);
    endtask

    int  n;
    int  seq[2];
    int  rem[2];
    int  stall[2];
    bit  acc_p[2];
    bit  err_p[2];
    bit  arm_p;
    bit  busy;
    int  dcnt;

    initial begin
        bus.req = 0; bus.s_valid = 0; bus.s_data = 0; bus.s_last = 0;
        bus.m_ready = 0; bus.m_done = 0;
        repeat (3) @(posedge clk);
        #4 chk("reset_gnt", bus.gnt, 0);
        chk("reset_m_valid", bus.m_valid, 0);
        tick(); rst = 1'b0;

        // Contention: 0, 1, then 0 again on the repeat.
        bus.req = 2'b11; bus.s_valid[1] = 1'b1; bus.s_data[15:8] = 8'h20;
        run_txn(0, 2, 8'h10, 4'hF, "c0");
        run_txn(1, 2, 8'h20, 4'hF, "c1");
        bus.req[1] = 1'b1; bus.s_valid[1] = 1'b1; bus.s_data[15:8] = 8'h40;
        run_txn(0, 2, 8'h30, 4'hF, "c2");
        run_txn(1, 2, 8'h40, 4'hF, "c3");

        // Single transaction 0x00, 0xAE, 0xAF.
        bus.req = 2'b01; bus.s_valid = 2'b01; bus.s_data = 16'h0000; bus.s_last = 0; bus.m_ready = 1'b1;
        #3 chk("t1_pre_gnt", bus.gnt, 0);
        tick(); #3 chk("t1_gnt", bus.gnt, 1);
        chk("t1_first0", bus.m_first, 1); chk("t1_data0", bus.m_data, 8'h00); chk("t1_last0", bus.m_last, 0);
        tick(); bus.s_data[7:0] = 8'hAE;
        #3 chk("t1_first1", bus.m_first, 0); chk("t1_data1", bus.m_data, 8'hAE); chk("t1_last1", bus.m_last, 0);
        tick(); bus.s_data[7:0] = 8'hAF; bus.s_last = 2'b01;
        #3 chk("t1_first2", bus.m_first, 0); chk("t1_last2", bus.m_last, 1);
        tick(); bus.s_valid = 0; bus.s_last = 0; bus.req = 0;
        #3 chk("t1_drain_gnt", bus.gnt, 1); chk("t1_drain_valid", bus.m_valid, 0);
        tick(); bus.m_done = 1'b1;
        tick(); bus.m_done = 1'b0;
        #3 chk("t1_release", bus.gnt, 0);
        tick();

        // Backpressure 1,0,0,1 over a 4-byte burst.
        run_txn(0, 4, 8'h50, 4'b1001, "bp");

        // Timeout: requester 1 sends one byte then stalls; requester 0 waits.
        bus.req = 2'b10; bus.s_valid = 2'b10; bus.s_data[15:8] = 8'h55; bus.s_last = 0; bus.m_ready = 1'b1;
        wait_acc(1, "to");
        tick(); bus.s_valid = 0; bus.req = 2'b01; n = 1;
        #3;
        while (!bus.m_abort && n < 40) begin tick(); n++; #3; end
        chk("to_delay", n, T + 1);
        chk("to_err", bus.err, 2);
        tick(); #3 chk("to_pulse", bus.m_abort, 0); chk("to_err_pulse", bus.err, 0);
        chk("to_hold", bus.gnt, 2); chk("to_hold_valid", bus.m_valid, 0);
        tick(); bus.m_done = 1'b1;
        tick(); bus.m_done = 1'b0;
        #3 chk("to_release", bus.gnt, 0);
        tick(); bus.s_valid = 2'b01; bus.s_data[7:0] = 8'h60; bus.s_last = 2'b01;
        #3 chk("to_next", bus.gnt, 1); chk("to_next_ready", bus.s_ready, 1);
        tick(); bus.s_valid = 0; bus.s_last = 0; bus.req = 0; bus.m_done = 1'b1;
        tick(); bus.m_done = 1'b0;
        tick();

        // Boundary: T-1 idle cycles then a byte must not abort.
        bus.req = 2'b01; bus.s_valid = 2'b01; bus.s_data[7:0] = 8'h70; bus.s_last = 0;
        wait_acc(0, "bd");
        for (int j = 1; j <= T - 1; j++) begin
            tick();
            if (j == 1) bus.s_valid = 0;
            #3 chk("bd_no_abort", bus.m_abort, 0);
        end
        tick(); bus.s_valid = 2'b01; bus.s_data[7:0] = 8'h71; bus.s_last = 2'b01;
        #3 chk("bd_late_ready", bus.s_ready, 1); chk("bd_late_abort", bus.m_abort, 0);
        tick(); bus.s_valid = 0; bus.s_last = 0; bus.req = 0; bus.m_done = 1'b1;
        #3 chk("bd_drain_abort", bus.m_abort, 0); chk("bd_drain_gnt", bus.gnt, 1);
        tick(); bus.m_done = 1'b0;
        #3 chk("bd_release", bus.gnt, 0);
        tick();

        // Asynchronous reset mid-GRANT, then priority returns to requester 0.
        bus.req = 2'b01; bus.s_valid = 2'b01; bus.s_data[7:0] = 8'h80; bus.m_ready = 1'b0;
        tick(); #1 chk("rs_pre_valid", bus.m_valid, 1);
        rst = 1'b1;
        #1 chk("rs_gnt", bus.gnt, 0); chk("rs_m_valid", bus.m_valid, 0); chk("rs_s_ready", bus.s_ready, 0);
        tick(); tick(); rst = 1'b0; bus.req = 2'b11; bus.s_valid = 0; bus.m_ready = 1'b1;
        #3 chk("rs_idle", bus.gnt, 0);
        tick(); bus.s_valid = 2'b01; bus.s_data[7:0] = 8'h81; bus.s_last = 2'b01;
        #3 chk("rs_priority", bus.gnt, 1);
        tick(); bus.s_valid = 0; bus.s_last = 0; bus.req = 0; bus.m_done = 1'b1;
        tick(); bus.m_done = 1'b0;
        tick();

        // Randomized traffic against the model.
        seq[0] = 0; seq[1] = 128; exp_seq[0] = 0; exp_seq[1] = 128;
        rem[0] = 0; rem[1] = 0; stall[0] = 0; stall[1] = 0;
        acc_p[0] = 0; acc_p[1] = 0; err_p[0] = 0; err_p[1] = 0; arm_p = 0; busy = 0; dcnt = 0;
        rand_phase = 1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            bus.m_done = 1'b0;
            if (arm_p) begin busy = 1; dcnt = $urandom_range(0, 3); end
            if (busy) begin
                if (dcnt == 0) begin bus.m_done = 1'b1; busy = 0; end
                else dcnt--;
            end else if ($urandom_range(0, 29) == 0) begin
                bus.m_done = 1'b1;
            end
            bus.m_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                if (acc_p[i]) begin
                    seq[i]++; rem[i]--;
                    if (rem[i] == 0) begin
                        bus.s_valid[i] = 1'b0; bus.s_last[i] = 1'b0; bus.req[i] = 1'b0;
                    end else begin
                        bus.s_data[8*i +: 8] = 8'(seq[i]); bus.s_last[i] = (rem[i] == 1);
                    end
                end
                if (err_p[i]) begin
                    rem[i] = 0; bus.s_valid[i] = 1'b0; bus.s_last[i] = 1'b0; bus.req[i] = 1'b0;
                end
                if (!bus.req[i] && rem[i] == 0 && $urandom_range(0, 5) == 0) begin
                    bus.req[i] = 1'b1; rem[i] = $urandom_range(1, 4); stall[i] = 0;
                end
                if (bus.req[i] && rem[i] > 0 && !bus.s_valid[i]) begin
                    if (stall[i] > 0) stall[i]--;
                    else if ($urandom_range(0, 39) == 0) stall[i] = $urandom_range(8, 24);
                    else if ($urandom_range(0, 2) != 0) begin
                        bus.s_valid[i] = 1'b1; bus.s_data[8*i +: 8] = 8'(seq[i]);
                        bus.s_last[i] = (rem[i] == 1);
                    end
                end
            end
            #3;
            for (int i = 0; i < 2; i++) begin
                acc_p[i] = bus.s_valid[i] & bus.s_ready[i];
                err_p[i] = bus.err[i];
            end
            arm_p = (bus.m_valid & bus.m_ready & bus.m_last) | bus.m_abort;
        end
        bus.req = 0; bus.s_valid = 0; bus.s_last = 0;
        repeat (4) begin tick(); bus.m_done = ~bus.m_done; end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Shares the single byte-level I2C master that drives the SSD1306 OLED (sda/sck) between two requesters: requester 0 is the display init/config sequencer and requester 1 is the frame/blink pixel streamer. It grants one requester at a time and holds the grant for a whole I2C transaction, from START to STOP. It forwards that requester's byte stream to the master and releases the bus only after the master reports STOP. A watchdog aborts any transaction whose owner stalls, so a hung requester cannot lock out the display.

## Interface
- TIMEOUT_CYCLES, 27000, stall limit in clk cycles (1 ms at 27 MHz); counter width is $clog2(TIMEOUT_CYCLES+1)
- clk  in  1  system clock, 27 MHz
- rst  in  1  reset, asynchronous, active-high
- req  in  2  per-requester transaction request, level
- gnt  out  2  one-hot grant, or all-zero
- s_valid  in  2  per-requester byte valid
- s_data  in  16  bytes; [7:0] requester 0, [15:8] requester 1
- s_last  in  2  marks the final byte of a transaction
- s_ready  out  2  byte accepted when s_valid[i] & s_ready[i]
- m_valid  out  1  byte valid to I2C master
- m_data  out  8  byte to I2C master
- m_first  out  1  master issues START before this byte
- m_last  out  1  master issues STOP after this byte
- m_ready  in  1  master accepts byte
- m_done  in  1  one-cycle pulse when STOP has completed
- m_abort  out  1  one-cycle pulse: master issues STOP immediately
- err  out  2  one-cycle pulse on the timed-out requester's bit

## Operation
- States: IDLE, GRANT, DRAIN, ABORT. Reset enters IDLE.
- IDLE: if any req bit is set, choose a winner with round-robin. The requester not served last wins. After reset, requester 0 has priority. Register gnt, clear the timeout counter, set first_pending, then go to GRANT.
- GRANT (winner g):
  - Combinational passthrough: m_valid = s_valid[g], m_data = byte g, m_last = s_last[g], s_ready[g] = m_ready. s_ready of the other requester is 0.
  - m_first = first_pending & m_valid. first_pending clears on the first accepted byte.
  - An accepted byte with s_last[g] moves to DRAIN. Otherwise the controller stays in GRANT.
  - Timeout counter: clears on each accepted byte. Increments every GRANT cycle without an accepted byte. On reaching TIMEOUT_CYCLES, go to ABORT.
- DRAIN: m_valid=0, s_ready=0, gnt held. On m_done, clear gnt, record g as last served, go to IDLE.
- ABORT: assert m_abort and err[g] for exactly the entry cycle. Then hold with m_valid=0 until m_done. Then clear gnt, record g as last served, go to IDLE.
- req dropping while granted is ignored. The grant is held until last/abort plus m_done.
- m_done outside DRAIN/ABORT is ignored.
- s_valid on a non-granted requester is ignored. Its s_ready stays 0 and no data is lost.
- Asynchronous rst in any state:
  - all outputs go to 0 and state goes to IDLE;
  - the priority pointer returns to requester 0;
  - the I2C master is reset by the same rst.

## Timing
- Reset values: gnt=0, s_ready=0, m_valid=0, m_data=0, m_first=0, m_last=0, m_abort=0, err=0.
- Grant latency: req sampled high in IDLE at edge t gives gnt high after edge t+1. The first byte can transfer in that same cycle (cycle t+1).
- Byte path is zero-latency combinational from s_* and m_ready. There are no bubbles between bytes.
- Release: m_done at cycle d gives gnt=0 from cycle d+1. The next grant appears at d+2.
- Both req held continuously: grants alternate 0,1,0,1…
- Timeout: with the last acceptance at cycle a, m_abort pulses at cycle a+TIMEOUT_CYCLES+1. A stall of exactly TIMEOUT_CYCLES-1 idle cycles does not abort.

## Test plan
- Single transaction: req0 with 3 bytes 0x00,0xAE,0xAF (last on 0xAF), m_ready=1. Required:
  - gnt=01 one cycle after req0;
  - m_first only on 0x00 and m_last only on 0xAF;
  - after m_done, gnt=00 on the next cycle.
- Contention: req0 and req1 asserted in the same cycle, each sending 2 bytes. Required grant order is 0, then 1, then 0 on the repeat. Requester 1 sees s_ready=0 throughout requester 0's transaction.
- Backpressure: m_ready toggles 1,0,0,1 during a 4-byte burst. Required: bytes arrive in order with no duplicates, and the timeout does not fire.
- Timeout: TIMEOUT_CYCLES=16; req1 sends 1 byte and then stalls.
  - m_abort and err=10 pulse exactly 17 cycles after that byte.
  - After m_done, a pending req0 is granted.
- Boundary: a stall of 15 idle cycles followed by a byte with TIMEOUT_CYCLES=16 must not abort.
- Reset mid-operation: assert rst during GRANT with m_valid=1. Required:
  - gnt, m_valid and s_ready go to 0 asynchronously;
  - after release, req1 and req0 together grant requester 0 first.
